// File: rtl/lstm_ram_pkg.sv
// Shared definitions for the LSTM state RAM: clear-sequencer states and
// the width helper used to size address and channel fields.
package lstm_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Bits needed to index n entries, never less than one so that a
  // single-entry dimension still gets a real port.
  function automatic int min1_clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lstm_ram_clr_seq.sv
// Clear sequencer: walks every address once, raising clr_we so the
// storage writes INIT_DATA into all channels at clr_addr each cycle.
module lstm_ram_clr_seq
  import lstm_ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = min1_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state;
  logic [ADDR_W-1:0] cnt;

  // Clear FSM: a start in IDLE arms the walk; the last address write
  // drops busy and fires a single clr_done. Starts while busy are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_addr = cnt;
  assign clr_we   = (state == CLEAR);

endmodule

// File: rtl/lstm_state_ram.sv
// Multi-channel LSTM state storage with one write port, one registered
// read port (write-first on collision) and a background clear walker.
module lstm_state_ram
  import lstm_ram_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 16,
  parameter int                CHANNELS  = 4,
  parameter logic [DATA_W-1:0] INIT_DATA = '0,
  localparam int               ADDR_W    = min1_clog2(DEPTH),
  localparam int               CH_W      = min1_clog2(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done
);

  logic [DATA_W-1:0] mem [CHANNELS][DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              user_ok;
  logic              wr_in_rng;
  logic              wr_acc;
  logic              rd_oor;
  logic              rd_acc;
  logic              rd_byp;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic              rd_err_p1;

  lstm_ram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  // User traffic is locked out while clearing and on the cycle a clear
  // is requested; cs gates only user traffic, never the clear walker.
  assign user_ok   = cs && !busy && !clr_start;
  assign wr_in_rng = (int'(wr_ch) < CHANNELS) && (int'(wr_addr) < DEPTH);
  assign wr_acc    = user_ok && wr_en && wr_in_rng;
  assign rd_oor    = (int'(rd_ch) >= CHANNELS) || (int'(rd_addr) >= DEPTH);
  assign rd_acc    = user_ok && rd_en;
  assign rd_byp    = wr_acc && (wr_ch == rd_ch) && (wr_addr == rd_addr);

  // Read word selection: out-of-range returns zero, a same-cycle write to
  // the same word is forwarded so the reader sees the new value.
  always_comb begin
    rd_word = '0;
    if (!rd_oor) begin
      if (rd_byp) begin
        rd_word = wr_data;
      end else begin
        rd_word = mem[rd_ch][rd_addr];
      end
    end
  end

  // Storage: reset and clear load INIT_DATA; clear wins over user writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem[c][a] <= INIT_DATA;
        end
      end
    end else if (clr_we) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mem[c][clr_addr] <= INIT_DATA;
      end
    end else if (wr_acc) begin
      mem[wr_ch][wr_addr] <= wr_data;
    end
  end

  // ---- stage p1: registered read result ----
  // Read register: data holds between accepted reads, valid/err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      rd_err_p1  <= 1'b0;
    end else begin
      vld_p1    <= rd_acc;
      rd_err_p1 <= rd_acc && rd_oor;
      if (rd_acc) begin
        rd_data_p1 <= rd_word;
      end
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;
  assign rd_err   = rd_err_p1;

endmodule

// File: tb/tb_lstm_state_ram.sv
// Bench for lstm_state_ram: a default instance (16x4) and a small
// instance (DEPTH=12, CHANNELS=3) for range-error behaviour.
module tb_lstm_state_ram;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        cs, wr_en, rd_en, clr_start;
  logic [1:0]  wr_ch, rd_ch;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, rd_err, busy, clr_done;

  logic        b_cs, b_wr_en, b_rd_en, b_clr_start;
  logic [1:0]  b_wr_ch, b_rd_ch;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_rd_data;
  logic        b_rd_valid, b_rd_err, b_busy, b_clr_done;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] model [4][16];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  lstm_state_ram #(.DATA_W(16), .DEPTH(16), .CHANNELS(4), .INIT_DATA(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
  );

  lstm_state_ram #(.DATA_W(16), .DEPTH(12), .CHANNELS(3), .INIT_DATA(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .cs(b_cs), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .rd_en(b_rd_en), .rd_ch(b_rd_ch), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err),
    .clr_start(b_clr_start), .busy(b_busy), .clr_done(b_clr_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    cs = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 16; a++)
        model[c][a] = 16'h0000;
  endtask

  task automatic write_a(input int ch, input int addr, input logic [15:0] data);
    cs = 1'b1; wr_en = 1'b1; wr_ch = 2'(ch); wr_addr = 4'(addr); wr_data = data;
    model[ch][addr] = data;
    step();
    wr_en = 1'b0;
  endtask

  // Back-to-back read of every word of dut_a against the model.
  task automatic sweep_a(input string tag);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 16; a++) begin
        cs = 1'b1; rd_en = 1'b1; rd_ch = 2'(c); rd_addr = 4'(a);
        qa.push_back('{data: model[c][a], err: 1'b0});
        step();
        e = qa.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== e.data || rd_err !== e.err) begin
          failures++;
          $display("FAIL %s ch%0d addr%0d: got data=%h valid=%b err=%b, want data=%h valid=1 err=%b",
                   tag, c, a, rd_data, rd_valid, rd_err, e.data, e.err);
        end
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_drop: got valid=%b, want 0", tag, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_a();
    wr_ch = '0; wr_addr = '0; wr_data = '0; rd_ch = '0; rd_addr = '0;
    b_cs = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr_start = 1'b0;
    b_wr_ch = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_ch = '0; b_rd_addr = '0;
    model_clear();
    step();
    step();
    checks++;
    if ({rd_data, rd_valid, rd_err, busy, clr_done} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h valid=%b err=%b busy=%b done=%b, want all 0",
               rd_data, rd_valid, rd_err, busy, clr_done);
    end
    checks++;
    if ({b_rd_data, b_rd_valid, b_rd_err, b_busy, b_clr_done} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs_b: got data=%h valid=%b err=%b, want all 0",
               b_rd_data, b_rd_valid, b_rd_err);
    end
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    exp_t e;
    write_a(2, 5, 16'hBEEF);
    rd_en = 1'b1; rd_ch = 2'd2; rd_addr = 4'd5;
    qa.push_back('{data: 16'hBEEF, err: 1'b0});
    step();
    e = qa.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e.data || rd_err !== 1'b0) begin
      failures++;
      $display("FAIL write_read: got data=%h valid=%b err=%b, want data=%h valid=1 err=0",
               rd_data, rd_valid, rd_err, e.data);
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL read_one_cycle_hold: got data=%h valid=%b, want data=beef valid=0",
               rd_data, rd_valid);
    end
  endtask

  task automatic test_write_first();
    exp_t e;
    cs = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; wr_addr = 4'd3; wr_data = 16'h1234;
    rd_en = 1'b1; rd_ch = 2'd1; rd_addr = 4'd3;
    model[1][3] = 16'h1234;
    qa.push_back('{data: 16'h1234, err: 1'b0});
    step();
    idle_a();
    e = qa.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e.data || rd_err !== 1'b0) begin
      failures++;
      $display("FAIL write_first: got data=%h valid=%b, want data=%h valid=1", rd_data, rd_valid, e.data);
    end
  endtask

  // Each cycle writes address i while reading address i-1 on channel 3.
  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      cs = 1'b1;
      wr_en = (i < 8); wr_ch = 2'd3; wr_addr = 4'(i); wr_data = 16'(16'h3000 + i * 7);
      if (i < 8) model[3][i] = 16'(16'h3000 + i * 7);
      rd_en = (i > 0); rd_ch = 2'd3; rd_addr = 4'(i - 1);
      if (i > 0) qa.push_back('{data: model[3][i-1], err: 1'b0});
      step();
      if (i > 0) begin
        e = qa.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== e.data) begin
          failures++;
          $display("FAIL back_to_back addr%0d: got data=%h valid=%b, want data=%h valid=1",
                   i - 1, rd_data, rd_valid, e.data);
        end
      end
    end
    idle_a();
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt;
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 16; a++)
        write_a(c, a, 16'(16'h8000 + c * 256 + a + 1));
    sweep_a("fill");
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      if (i == 9) begin
        checks++;
        if (rd_valid !== 1'b0) begin
          failures++;
          $display("FAIL read_during_clear: got valid=%b, want 0", rd_valid);
        end
      end
      clr_start = (i == 5);
      rd_en = (i == 8); rd_ch = 2'd0; rd_addr = 4'd0;
      step();
    end
    idle_a();
    checks++;
    if (busy_cnt != 16) begin
      failures++;
      $display("FAIL clear_busy_cycles: got %0d, want 16", busy_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL clear_done_pulses: got %0d, want 1", done_cnt);
    end
    model_clear();
    sweep_a("after_clear");
  endtask

  task automatic test_cs_gate();
    exp_t e;
    write_a(0, 7, 16'h5555);
    cs = 1'b0; wr_en = 1'b1; wr_ch = 2'd0; wr_addr = 4'd7; wr_data = 16'hDEAD;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_ch = 2'd0; rd_addr = 4'd7;
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL cs_gate_read: got valid=%b, want 0", rd_valid);
    end
    cs = 1'b1;
    qa.push_back('{data: 16'h5555, err: 1'b0});
    step();
    rd_en = 1'b0;
    e = qa.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e.data) begin
      failures++;
      $display("FAIL cs_gate_write: got data=%h valid=%b, want data=%h valid=1", rd_data, rd_valid, e.data);
    end

    b_wr_en = 1'b1; b_wr_ch = 2'd0; b_wr_addr = 4'd2; b_wr_data = 16'h7777;
    step();
    b_wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b_rd_en = 1'b1;
      case (k)
        0: begin b_rd_ch = 2'd0; b_rd_addr = 4'd2;  qb.push_back('{data: 16'h7777, err: 1'b0}); end
        1: begin b_rd_ch = 2'd0; b_rd_addr = 4'd15; qb.push_back('{data: 16'h0000, err: 1'b1}); end
        default: begin b_rd_ch = 2'd3; b_rd_addr = 4'd0; qb.push_back('{data: 16'h0000, err: 1'b1}); end
      endcase
      step();
      e = qb.pop_front();
      checks++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== e.data || b_rd_err !== e.err) begin
        failures++;
        $display("FAIL range_read_%0d: got data=%h valid=%b err=%b, want data=%h valid=1 err=%b",
                 k, b_rd_data, b_rd_valid, b_rd_err, e.data, e.err);
      end
    end
    b_rd_en = 1'b0;
    step();
    checks++;
    if (b_rd_valid !== 1'b0 || b_rd_err !== 1'b0) begin
      failures++;
      $display("FAIL range_err_drop: got valid=%b err=%b, want 0 0", b_rd_valid, b_rd_err);
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    int seen;
    write_a(3, 10, 16'h9999);
    write_a(0, 15, 16'h0F0F);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_clear_busy: got busy=%b, want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_busy: got busy=%b done=%b, want 0 0", busy, clr_done);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    model_clear();
    wr_en = 1'b1; wr_ch = 2'd1; wr_addr = 4'd1; wr_data = 16'hABCD;
    rd_en = 1'b1; rd_ch = 2'd3; rd_addr = 4'd10;
    model[1][1] = 16'hABCD;
    qa.push_back('{data: 16'h0000, err: 1'b0});
    step();
    idle_a();
    e = qa.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e.data) begin
      failures++;
      $display("FAIL first_edge_after_reset: got data=%h valid=%b, want data=%h valid=1",
               rd_data, rd_valid, e.data);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (clr_done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL aborted_clear_activity: got %0d busy/done cycles, want 0", seen);
    end
    sweep_a("after_reset");
  endtask

  task automatic test_write_with_clr();
    exp_t e;
    bit   got_done;
    write_a(2, 9, 16'h2222);
    cs = 1'b1; clr_start = 1'b1;
    wr_en = 1'b1; wr_ch = 2'd2; wr_addr = 4'd9; wr_data = 16'h1111;
    rd_en = 1'b1; rd_ch = 2'd2; rd_addr = 4'd9;
    step();
    idle_a();
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_priority: got valid=%b busy=%b, want valid=0 busy=1", rd_valid, busy);
    end
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      step();
      if (clr_done === 1'b1) got_done = 1'b1;
    end
    checks++;
    if (!got_done) begin
      failures++;
      $display("FAIL clr_done_timeout: got no clr_done in 40 cycles, want one");
    end
    model_clear();
    rd_en = 1'b1; rd_ch = 2'd2; rd_addr = 4'd9;
    qa.push_back('{data: 16'h0000, err: 1'b0});
    step();
    rd_en = 1'b0;
    e = qa.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e.data) begin
      failures++;
      $display("FAIL dropped_write: got data=%h valid=%b, want data=%h valid=1", rd_data, rd_valid, e.data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_first();
    test_back_to_back();
    test_clear();
    test_cs_gate();
    test_reset_mid_clear();
    test_write_with_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
